// File: rtl/w_writeback_stage.sv
// M/W pipeline register and GRF write-back formation for the P6 MIPS pipeline.
// Also the W-level forwarding source for the hazard unit.
module w_writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_A3,
  input  logic        M_RegWrite,
  input  logic [1:0]  M_WDSel,
  input  logic [31:0] M_ALUOut,
  input  logic [31:0] M_DMRD,
  input  logic [2:0]  M_LoadType,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD3,
  output logic        W_WE,
  output logic [31:0] W_PC,
  output logic [31:0] W_WriteCnt
);

  typedef enum logic [1:0] {WD_ALU = 2'd0, WD_MEM = 2'd1, WD_LINK = 2'd2, WD_RSVD = 2'd3} wdsel_e;
  typedef enum logic [2:0] {LD_LW = 3'd0, LD_LB = 3'd1, LD_LBU = 3'd2, LD_LH = 3'd3, LD_LHU = 3'd4} load_e;

  logic [31:0] pc_q, pc_d;
  logic [4:0]  a3_q, a3_d;
  logic        rw_q, rw_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dmrd_q, dmrd_d;
  logic [2:0]  lt_q, lt_d;
  logic [31:0] cnt_q, cnt_d;

  logic        we;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Flush wins over en; without either the W bundle simply holds.
  always_comb begin
    pc_d   = pc_q;
    a3_d   = a3_q;
    rw_d   = rw_q;
    sel_d  = sel_q;
    alu_d  = alu_q;
    dmrd_d = dmrd_q;
    lt_d   = lt_q;
    if (flush) begin
      pc_d   = RESET_PC;
      a3_d   = '0;
      rw_d   = 1'b0;
      sel_d  = '0;
      alu_d  = '0;
      dmrd_d = '0;
      lt_d   = '0;
    end else if (en) begin
      pc_d   = M_PC;
      a3_d   = M_A3;
      rw_d   = M_RegWrite;
      sel_d  = M_WDSel;
      alu_d  = M_ALUOut;
      dmrd_d = M_DMRD;
      lt_d   = M_LoadType;
    end
  end

  assign we = rw_q && (a3_q != '0);

  // Counted on every edge the W slot presents a write, held or not.
  always_comb begin
    cnt_d = cnt_q;
    if (we) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      a3_q   <= '0;
      rw_q   <= 1'b0;
      sel_q  <= '0;
      alu_q  <= '0;
      dmrd_q <= '0;
      lt_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      a3_q   <= a3_d;
      rw_q   <= rw_d;
      sel_q  <= sel_d;
      alu_q  <= alu_d;
      dmrd_q <= dmrd_d;
      lt_q   <= lt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    ld_byte = dmrd_q[7:0];
    case (alu_q[1:0])
      2'd0:    ld_byte = dmrd_q[7:0];
      2'd1:    ld_byte = dmrd_q[15:8];
      2'd2:    ld_byte = dmrd_q[23:16];
      default: ld_byte = dmrd_q[31:24];
    endcase
    ld_half = alu_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
    case (load_e'(lt_q))
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_data = {24'h0, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = dmrd_q;
    endcase
  end

  always_comb begin
    W_WD3 = '0;
    case (wdsel_e'(sel_q))
      WD_ALU:  W_WD3 = alu_q;
      WD_MEM:  W_WD3 = ld_data;
      WD_LINK: W_WD3 = pc_q + 32'd8;
      default: W_WD3 = '0;
    endcase
  end

  assign W_A3       = a3_q;
  assign W_WE       = we;
  assign W_PC       = pc_q;
  assign W_WriteCnt = cnt_q;

endmodule

// File: tb/tb_w_writeback_stage.sv
// Directed scoreboard bench for w_writeback_stage: expected W bundles are queued
// as M bundles are driven and compared one cycle later.
module tb_w_writeback_stage;

  logic        clk, reset, en, flush;
  logic [31:0] M_PC, M_ALUOut, M_DMRD;
  logic [4:0]  M_A3;
  logic        M_RegWrite;
  logic [1:0]  M_WDSel;
  logic [2:0]  M_LoadType;
  logic [4:0]  W_A3;
  logic [31:0] W_WD3, W_PC, W_WriteCnt;
  logic        W_WE;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string       tag;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_cnt = '0;
  logic        cur_we  = 1'b0;

  w_writeback_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .M_PC(M_PC), .M_A3(M_A3), .M_RegWrite(M_RegWrite), .M_WDSel(M_WDSel),
    .M_ALUOut(M_ALUOut), .M_DMRD(M_DMRD), .M_LoadType(M_LoadType),
    .W_A3(W_A3), .W_WD3(W_WD3), .W_WE(W_WE), .W_PC(W_PC), .W_WriteCnt(W_WriteCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] a3, input logic rw,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] dmrd, input logic [2:0] lt);
    M_PC = pc; M_A3 = a3; M_RegWrite = rw; M_WDSel = sel;
    M_ALUOut = alu; M_DMRD = dmrd; M_LoadType = lt;
  endtask

  task automatic push(input string tag, input logic [4:0] a3, input logic [31:0] wd3,
                      input logic we, input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.a3 = a3; e.wd3 = wd3; e.we = we; e.pc = pc;
    sb.push_back(e);
  endtask

  // One clock edge; pop the expected W bundle and compare away from the edge.
  task automatic retire();
    exp_t e;
    if (cur_we) exp_cnt++;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got %0d expected >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cur_we = e.we;
      chk({e.tag, "_a3"},  {27'h0, W_A3}, {27'h0, e.a3});
      chk({e.tag, "_wd3"}, W_WD3, e.wd3);
      chk({e.tag, "_we"},  {31'h0, W_WE}, {31'h0, e.we});
      chk({e.tag, "_pc"},  W_PC, e.pc);
      chk({e.tag, "_cnt"}, W_WriteCnt, exp_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    drive(32'h0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a3",  {27'h0, W_A3}, 32'h0);
    chk("rst_wd3", W_WD3, 32'h0);
    chk("rst_we",  {31'h0, W_WE}, 32'h0);
    chk("rst_pc",  W_PC, 32'h0000_3000);
    chk("rst_cnt", W_WriteCnt, 32'h0);
    @(negedge clk);
    reset = 1'b0; en = 1'b1;

    drive(32'h3004, 5'd8, 1'b1, 2'd0, 32'h1234_5678, 32'h0, 3'd0);
    push("alu", 5'd8, 32'h1234_5678, 1'b1, 32'h3004); retire();
    drive(32'h3008, 5'd9, 1'b1, 2'd1, 32'h0000_1003, 32'h80FF_7F01, 3'd1);
    push("lb_off3", 5'd9, 32'hFFFF_FF80, 1'b1, 32'h3008); retire();
    drive(32'h300C, 5'd9, 1'b1, 2'd1, 32'h0000_1003, 32'h80FF_7F01, 3'd2);
    push("lbu_off3", 5'd9, 32'h0000_0080, 1'b1, 32'h300C); retire();
    drive(32'h3010, 5'd9, 1'b1, 2'd1, 32'h0000_1001, 32'h80FF_7F01, 3'd1);
    push("lb_off1", 5'd9, 32'h0000_007F, 1'b1, 32'h3010); retire();
    drive(32'h3014, 5'd9, 1'b1, 2'd1, 32'h0000_1002, 32'h80FF_7F01, 3'd3);
    push("lh_off2", 5'd9, 32'hFFFF_80FF, 1'b1, 32'h3014); retire();
    drive(32'h3018, 5'd9, 1'b1, 2'd1, 32'h0000_1000, 32'h80FF_7F01, 3'd4);
    push("lhu_off0", 5'd9, 32'h0000_7F01, 1'b1, 32'h3018); retire();
    drive(32'h301C, 5'd9, 1'b1, 2'd1, 32'h0000_1003, 32'h80FF_7F01, 3'd4);
    push("lhu_off3", 5'd9, 32'h0000_80FF, 1'b1, 32'h301C); retire();
    drive(32'h3020, 5'd9, 1'b1, 2'd1, 32'h0000_1002, 32'h80FF_7F01, 3'd0);
    push("lw_off2", 5'd9, 32'h80FF_7F01, 1'b1, 32'h3020); retire();
    drive(32'h3024, 5'd9, 1'b1, 2'd1, 32'h0000_1003, 32'h80FF_7F01, 3'd6);
    push("lt6_as_lw", 5'd9, 32'h80FF_7F01, 1'b1, 32'h3024); retire();
    drive(32'h3010, 5'd31, 1'b1, 2'd2, 32'h0, 32'h0, 3'd0);
    push("jal", 5'd31, 32'h0000_3018, 1'b1, 32'h3010); retire();
    drive(32'hFFFF_FFFC, 5'd31, 1'b1, 2'd2, 32'h0, 32'h0, 3'd0);
    push("jal_wrap", 5'd31, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC); retire();
    drive(32'h3028, 5'd5, 1'b1, 2'd3, 32'h5555_AAAA, 32'h0, 3'd0);
    push("sel3", 5'd5, 32'h0, 1'b1, 32'h3028); retire();
    drive(32'h302C, 5'd0, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0);
    push("r0_write", 5'd0, 32'hDEAD_BEEF, 1'b0, 32'h302C); retire();
    drive(32'h3030, 5'd7, 1'b0, 2'd0, 32'h0000_0077, 32'h0, 3'd0);
    push("no_regwrite", 5'd7, 32'h0000_0077, 1'b0, 32'h3030); retire();

    // Stall: W holds (and keeps counting), then flush with en=0 bubbles it.
    drive(32'h3034, 5'd10, 1'b1, 2'd0, 32'hCAFE_0001, 32'h0, 3'd0);
    push("pre_stall", 5'd10, 32'hCAFE_0001, 1'b1, 32'h3034); retire();
    en = 1'b0;
    drive(32'h9999_0000, 5'd3, 1'b1, 2'd0, 32'h1111_1111, 32'h0, 3'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      push("hold", 5'd10, 32'hCAFE_0001, 1'b1, 32'h3034); retire();
    end
    flush = 1'b1;
    push("flush_en0", 5'd0, 32'h0, 1'b0, 32'h0000_3000); retire();
    en = 1'b1;
    drive(32'h3038, 5'd11, 1'b1, 2'd0, 32'h0000_00BB, 32'h0, 3'd0);
    push("flush_en1", 5'd0, 32'h0, 1'b0, 32'h0000_3000); retire();
    flush = 1'b0;

    drive(32'h303C, 5'd12, 1'b1, 2'd0, 32'h0000_0001, 32'h0, 3'd0);
    push("pre_wrap", 5'd12, 32'h0000_0001, 1'b1, 32'h303C); retire();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    drive(32'h3040, 5'd13, 1'b0, 2'd0, 32'h0000_0002, 32'h0, 3'd0);
    push("cnt_wrap", 5'd13, 32'h0000_0002, 1'b0, 32'h3040); retire();

    drive(32'h3044, 5'd14, 1'b1, 2'd0, 32'h0000_0ABC, 32'h0, 3'd0);
    push("pre_async", 5'd14, 32'h0000_0ABC, 1'b1, 32'h3044); retire();
    #2;
    reset = 1'b1;
    #1;
    chk("async_we",  {31'h0, W_WE}, 32'h0);
    chk("async_a3",  {27'h0, W_A3}, 32'h0);
    chk("async_wd3", W_WD3, 32'h0);
    chk("async_pc",  W_PC, 32'h0000_3000);
    chk("async_cnt", W_WriteCnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/w_writeback_stage.md
Name: w_writeback_stage

Overview:
- M/W pipeline register plus write-back data formation for the P6 five-stage MIPS pipeline.
- It is the writer end of the GRF write port: it latches the M-stage result bundle, forms the final write value (ALU result, extended load data, or link address) and drives the GRF's write address, write data, write enable and write PC.
- Its W-stage outputs also serve as the W-level forwarding source for the hazard unit.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into the registered PC on reset and on flush.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  pipeline-register enable; 0 holds the current W contents
- flush  input  1  load a bubble instead of the M bundle (priority over en)
- M_PC  input  32  PC of the instruction leaving M
- M_A3  input  5  destination register number
- M_RegWrite  input  1  instruction writes the GRF
- M_WDSel  input  2  0 = ALU result, 1 = load data, 2 = PC+8, 3 = reserved
- M_ALUOut  input  32  ALU/MDU result; for loads, the effective address
- M_DMRD  input  32  raw aligned word read from data memory
- M_LoadType  input  3  0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu, 5-7 = treated as lw
- W_A3  output  5  GRF write address
- W_WD3  output  32  GRF write data
- W_WE  output  1  GRF write enable
- W_PC  output  32  PC of the W instruction, used for the write trace
- W_WriteCnt  output  32  count of committed non-zero-register writes

Behaviour:
- Registered fields: PC, A3, RegWrite, WDSel, ALUOut, DMRD, LoadType.
- Reset (async, any time, including mid-stall):
  - PC = RESET_PC; all other fields 0; W_WriteCnt = 0.
  - Outputs immediately: W_A3 = 0, W_WD3 = 0, W_WE = 0, W_PC = RESET_PC.
- Rising edge, reset low:
  - flush = 1: load a bubble (PC = RESET_PC, all other fields 0), regardless of en.
  - else en = 1: capture all M_* inputs.
  - else: hold all fields.
- Latency: one cycle from the M bundle to the W outputs. No internal forwarding; the GRF performs the same-cycle bypass.
- W_WE = RegWrite && (A3 != 0). A write to $0 is suppressed entirely: W_WE = 0 and it is not counted. W_A3 always reflects the registered A3.
- W_WD3 selection (combinational from registered fields):
  - WDSel 0: ALUOut.
  - WDSel 1: extended load data, from DMRD and off = ALUOut[1:0].
    - lw: DMRD, offset ignored.
    - lb/lbu: byte = DMRD[8*off+7 : 8*off]; lb sign-extends, lbu zero-extends.
    - lh/lhu: half = ALUOut[1] ? DMRD[31:16] : DMRD[15:0]; ALUOut[0] ignored; lh sign-extends, lhu zero-extends.
  - WDSel 2: PC + 8, modulo 2^32.
  - WDSel 3: 32'h0.
- W_WD3 is valid whenever W_WE = 1. When W_WE = 0 it is still the selected value, not forced to zero.
- W_WriteCnt increments by 1 on each rising edge where W_WE = 1, and wraps from 32'hFFFF_FFFF to 0.
  - The count is taken on the edge that retires the W instruction, so a held W instruction (en = 0, W_WE = 1) counts once per cycle held.
  - Verification therefore compares the count only over stall-free windows.
- Simultaneous flush and en = 0: the bubble wins. W_WriteCnt still counts the outgoing W instruction on that edge if its W_WE = 1.

Test Plan:
- Reset asserted mid-cycle with W holding a valid write -> outputs drop immediately with no clock edge: W_WE = 0, W_A3 = 0, W_PC = 32'h0000_3000, W_WriteCnt = 0.
- M_PC = 32'h3004, A3 = 8, RegWrite = 1, WDSel = 0, ALUOut = 32'h1234_5678, en = 1 -> next cycle W_WE = 1, W_A3 = 8, W_WD3 = 32'h1234_5678, W_PC = 32'h3004; after a further edge W_WriteCnt = 1.
- DMRD = 32'h80FF_7F01 with WDSel = 1:
  - lb, off 3 -> 32'hFFFF_FF80.
  - lbu, off 3 -> 32'h0000_0080.
  - lb, off 1 -> 32'h0000_007F.
  - lh, off 2 -> 32'hFFFF_80FF.
  - lhu, off 0 -> 32'h0000_7F01.
  - lw, off 2 -> 32'h80FF_7F01.
- jal: WDSel = 2, PC = 32'h0000_3010, A3 = 31 -> W_WD3 = 32'h0000_3018. With PC = 32'hFFFF_FFFC -> W_WD3 = 32'h0000_0004.
- RegWrite = 1, A3 = 0 -> W_WE = 0 and W_WriteCnt unchanged.
- en = 0 for 3 cycles -> W fields hold. flush = 1 with en = 0 -> bubble: W_WE = 0, W_PC = 32'h3000.
- Preload W_WriteCnt = 32'hFFFF_FFFF via forced writes -> one more write wraps it to 0.
